// File: rtl/tile_map_ctrl.sv
// Tile map controller: 255-word packed sprite-index map with a registered display read port,
// a single-tile write port and a full-map clear, both committed only during blanking.
module tile_map_ctrl #(
   parameter int N_PER_ROW      = 60,
   parameter int N_ROWS         = 34,
   parameter int IDX_W          = 4,
   parameter int TILES_PER_WORD = 8,
   parameter int N_WORDS        = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  current_tile,
   input  logic        vde,
   output logic [31:0] sprite_addr,
   input  logic        wr_req,
   input  logic [5:0]  wr_col,
   input  logic [5:0]  wr_row,
   input  logic [3:0]  wr_idx,
   output logic        wr_ack,
   output logic        wr_err,
   input  logic        clr_req,
   input  logic [3:0]  clr_idx,
   output logic        busy
);

   localparam int             WORD_W   = IDX_W * TILES_PER_WORD;
   localparam logic [7:0]     DEPTH8   = 8'(N_WORDS);
   localparam logic [7:0]     LAST_PTR = 8'(N_WORDS - 1);
   localparam logic [5:0]     COLS6    = 6'(N_PER_ROW);
   localparam logic [5:0]     ROWS6    = 6'(N_ROWS);

   typedef enum logic [1:0] {IDLE, WPEND, CLEAR} state_t;

   state_t              state_q;
   logic [7:0]          ptr_q;
   logic [7:0]          word_q;
   logic [2:0]          nib_q;
   logic [IDX_W-1:0]    idx_q;
   logic                oor_q;
   logic [IDX_W-1:0]    fill_q;
   logic                ack_q;
   logic                err_q;
   logic                busy_q;
   logic [WORD_W-1:0]   rd_q;

   logic [10:0]               tile_d;
   logic                      oor_d;
   logic [7:0]                rd_addr;
   logic [WORD_W-1:0]         rd_word;
   logic [TILES_PER_WORD-1:0] mem_we;
   logic [7:0]                mem_addr;
   logic [IDX_W-1:0]          lane_wdata;

   assign tile_d  = {5'd0, wr_row} * 11'(N_PER_ROW) + {5'd0, wr_col};
   assign oor_d   = (wr_col >= COLS6) || (wr_row >= ROWS6);
   assign rd_addr = (current_tile < DEPTH8) ? current_tile : 8'd0;

   // A single-tile write enables only its own nibble lane, so neighbours are never rewritten.
   always_comb begin
      mem_we     = '0;
      mem_addr   = word_q;
      lane_wdata = idx_q;
      if (state_q == WPEND && !oor_q && !vde) begin
         mem_we[nib_q] = 1'b1;
      end else if (state_q == CLEAR && !vde) begin
         mem_we     = '1;
         mem_addr   = ptr_q;
         lane_wdata = fill_q;
      end
   end

   for (genvar gi = 0; gi < TILES_PER_WORD; gi++) begin : g_lane
      logic [IDX_W-1:0] lane_mem [N_WORDS];

      always_ff @(posedge clk) begin
         if (mem_we[gi]) lane_mem[mem_addr] <= lane_wdata;
      end

      assign rd_word[gi*IDX_W +: IDX_W] = lane_mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= (current_tile < DEPTH8) ? rd_word : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         word_q  <= '0;
         nib_q   <= '0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         fill_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A clear takes priority; a simultaneous write stays pending on wr_req.
               if (clr_req) begin
                  fill_q  <= clr_idx;
                  ptr_q   <= '0;
                  state_q <= CLEAR;
                  busy_q  <= 1'b1;
               end else if (wr_req) begin
                  word_q  <= tile_d[10:3];
                  nib_q   <= tile_d[2:0];
                  idx_q   <= wr_idx;
                  oor_q   <= oor_d;
                  state_q <= WPEND;
                  busy_q  <= 1'b1;
               end
            end
            WPEND: begin
               if (oor_q) begin
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (!vde) begin
                  ack_q   <= 1'b1;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            CLEAR: begin
               if (!vde) begin
                  if (ptr_q == LAST_PTR) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ptr_q <= ptr_q + 8'd1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sprite_addr = rd_q;
   assign wr_ack      = ack_q;
   assign wr_err      = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Bench for tile_map_ctrl: a tile-indexed reference map checked against full and
// single-word readbacks, write handshakes and clear timing.
module tb_tile_map_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  current_tile = '0;
   logic        vde = 1'b0;
   logic [31:0] sprite_addr;
   logic        wr_req = 1'b0;
   logic [5:0]  wr_col = '0;
   logic [5:0]  wr_row = '0;
   logic [3:0]  wr_idx = '0;
   logic        wr_ack;
   logic        wr_err;
   logic        clr_req = 1'b0;
   logic [3:0]  clr_idx = '0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Reference map indexed by linear tile number (row*60 + col).
   logic [3:0] model [0:2039];

   always #5 clk = ~clk;

   tile_map_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .current_tile (current_tile),
      .vde          (vde),
      .sprite_addr  (sprite_addr),
      .wr_req       (wr_req),
      .wr_col       (wr_col),
      .wr_row       (wr_row),
      .wr_idx       (wr_idx),
      .wr_ack       (wr_ack),
      .wr_err       (wr_err),
      .clr_req      (clr_req),
      .clr_idx      (clr_idx),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int w);
      logic [31:0] r;
      r = '0;
      if (w < 255) begin
         for (int k = 0; k < 8; k++) r[4*k +: 4] = model[8*w + k];
      end
      return r;
   endfunction

   task automatic read_word(input string tag, input int w);
      current_tile = 8'(w);
      @(negedge clk);
      chk($sformatf("%s_w%0d", tag, w), sprite_addr, exp_word(w));
   endtask

   task automatic readback_all(input string tag);
      for (int w = 0; w < 256; w++) read_word(tag, w);
   endtask

   task automatic do_clear(input logic [3:0] val);
      int n;
      n = 0;
      vde = 1'b0;
      clr_req = 1'b1;
      clr_idx = val;
      @(negedge clk);
      clr_req = 1'b0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("clear_busy_cycles", 32'(n), 32'd255);
      for (int t = 0; t < 2040; t++) model[t] = val;
   endtask

   // Holds the request until ack is seen, then drops it before the next edge.
   task automatic do_write(input logic [5:0] row, input logic [5:0] col, input logic [3:0] idx,
                           input bit rnd_vde, output int lat);
      int  n;
      bit  oor;
      logic last_vde;
      oor = (row >= 6'd34) || (col >= 6'd60);
      wr_req = 1'b1;
      wr_row = row;
      wr_col = col;
      wr_idx = idx;
      if (rnd_vde) vde = 1'($urandom_range(0, 1));
      last_vde = vde;
      @(negedge clk);
      n = 1;
      while (wr_ack !== 1'b1 && n < 2000) begin
         if (rnd_vde) vde = 1'($urandom_range(0, 1));
         last_vde = vde;
         @(negedge clk);
         n++;
      end
      wr_req = 1'b0;
      lat = n - 1;
      chk_b("wr_ack_seen", wr_ack, 1'b1);
      chk_b("wr_err", wr_err, oor);
      if (!oor) begin
         chk_b("commit_in_blanking", last_vde, 1'b0);
         model[int'(row) * 60 + int'(col)] = idx;
      end
   endtask

   initial begin
      int lat;
      int n;
      int tile;
      int w;
      logic [5:0]  row;
      logic [5:0]  col;
      logic [3:0]  idx;
      logic [3:0]  fill;
      logic [31:0] old;
      logic        last_vde;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_sprite", sprite_addr, 32'd0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_ack", wr_ack, 1'b0);
      chk_b("rst_err", wr_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_b("idle_busy", busy, 1'b0);

      // Full clear with 3 in blanking, then every word and the out-of-range address
      do_clear(4'd3);
      readback_all("clr3");
      current_tile = 8'd255;
      @(negedge clk);
      chk("tile255_zero", sprite_addr, 32'd0);

      // Clear with 0, then row 1 col 5 = 0xA lands in word 8 nibble 1
      do_clear(4'd0);
      do_write(6'd1, 6'd5, 4'hA, 1'b0, lat);
      chk("wr_latency", 32'(lat), 32'd1);
      @(negedge clk);
      chk_b("ack_one_pulse", wr_ack, 1'b0);
      chk_b("busy_after_ack", busy, 1'b0);
      read_word("w8", 8);
      chk("w8_const", sprite_addr, 32'h000000A0);

      // Last tile of the grid: word 254 nibble 7
      do_write(6'd33, 6'd59, 4'h5, 1'b0, lat);
      chk("wr_latency_last", 32'(lat), 32'd1);
      read_word("last_tile", 254);

      // Write held off by 100 cycles of active video
      row = 6'($urandom_range(0, 33));
      col = 6'($urandom_range(0, 59));
      tile = int'(row) * 60 + int'(col);
      w = tile / 8;
      idx = model[tile] ^ 4'($urandom_range(1, 15));
      current_tile = 8'(w);
      vde = 1'b1;
      @(negedge clk);
      old = exp_word(w);
      wr_req = 1'b1;
      wr_row = row;
      wr_col = col;
      wr_idx = idx;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk_b("vde1_no_ack", wr_ack, 1'b0);
         chk("vde1_hold", sprite_addr, old);
      end
      vde = 1'b0;
      @(negedge clk);
      chk_b("vde0_ack", wr_ack, 1'b1);
      chk_b("vde0_err", wr_err, 1'b0);
      chk("rdw_old_data", sprite_addr, old);
      wr_req = 1'b0;
      model[tile] = idx;
      @(negedge clk);
      chk("vde0_new_data", sprite_addr, exp_word(w));
      chk_b("vde0_ack_drop", wr_ack, 1'b0);

      // Out-of-range coordinates: error ack after one cycle even in active video
      do_write(6'd0, 6'd60, 4'hF, 1'b0, lat);
      chk("oor_col_latency", 32'(lat), 32'd1);
      vde = 1'b1;
      do_write(6'd34, 6'd0, 4'hF, 1'b0, lat);
      chk("oor_row_latency", 32'(lat), 32'd1);
      vde = 1'b0;
      readback_all("after_oor");

      // Random writes with random blanking, some out of range
      for (int i = 0; i < 16; i++) begin
         row = 6'($urandom_range(0, 40));
         col = 6'($urandom_range(0, 63));
         idx = 4'($urandom_range(0, 15));
         do_write(row, col, idx, 1'b1, lat);
         vde = 1'b0;
         if (row < 6'd34 && col < 6'd60) read_word("rnd_wr", (int'(row) * 60 + int'(col)) / 8);
         else                            read_word("rnd_oor", $urandom_range(0, 255));
      end

      // Clear and write requested together, vde toggling every cycle
      fill = 4'($urandom_range(1, 15));
      row = 6'($urandom_range(0, 33));
      col = 6'($urandom_range(0, 59));
      idx = fill ^ 4'($urandom_range(1, 15));
      vde = 1'b0;
      clr_req = 1'b1;
      clr_idx = fill;
      wr_req = 1'b1;
      wr_row = row;
      wr_col = col;
      wr_idx = idx;
      last_vde = vde;
      @(negedge clk);
      clr_req = 1'b0;
      n = 1;
      while (wr_ack !== 1'b1 && n < 3000) begin
         vde = ~vde;
         last_vde = vde;
         @(negedge clk);
         n++;
      end
      wr_req = 1'b0;
      chk_b("combo_ack", wr_ack, 1'b1);
      chk_b("combo_err", wr_err, 1'b0);
      chk_b("combo_ack_after_clear", n > 500, 1'b1);
      chk_b("combo_commit_blank", last_vde, 1'b0);
      vde = 1'b0;
      for (int t = 0; t < 2040; t++) model[t] = fill;
      model[int'(row) * 60 + int'(col)] = idx;
      @(negedge clk);
      readback_all("combo");

      // Reset in the middle of a clear, pointer at 100
      idx = fill ^ 4'($urandom_range(1, 15));
      current_tile = 8'd200;
      vde = 1'b0;
      clr_req = 1'b1;
      clr_idx = idx;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (100) @(negedge clk);
      chk_b("midclr_busy", busy, 1'b1);
      chk("midclr_word200_old", sprite_addr, exp_word(200));
      rst_n = 1'b0;
      #1;
      chk_b("async_rst_busy", busy, 1'b0);
      chk("async_rst_sprite", sprite_addr, 32'd0);
      chk_b("async_rst_ack", wr_ack, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 800; t++) model[t] = idx;
      readback_all("partial");
      do_clear(4'($urandom_range(0, 15)));
      readback_all("reclear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_map_ctrl.md
Name: tile_map_ctrl

Overview:
- Owns the on-screen tile map: 60 x 34 grid of 4-bit sprite indices, packed 8 per 32-bit word (255 words).
- Supplies the packed word for the tile group the pixel generator is currently drawing, one cycle after that group's word address is presented.
- Shares the map between the display read path and a game-logic write port, and sequences a full-map clear.
- Map updates are committed only during blanking (vde=0), so no frame ever shows a half-updated map.

Parameters:
- N_PER_ROW, 60, tiles per grid row.
- N_ROWS, 34, tile rows (33.75 rounded up).
- IDX_W, 4, bits per sprite index.
- TILES_PER_WORD, 8, indices packed per map word.
- N_WORDS, 255, map depth = ceil(N_PER_ROW*N_ROWS/TILES_PER_WORD).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- current_tile  in  8  word address of the tile group being drawn.
- vde  in  1  video data enable; 1 = active video.
- sprite_addr  out  32  packed indices for current_tile; nibble k belongs to tile 8*current_tile+k.
- wr_req  in  1  single-tile write request; held until wr_ack.
- wr_col  in  6  target column, 0..59.
- wr_row  in  6  target row, 0..33.
- wr_idx  in  4  sprite index to store.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_err  out  1  one-cycle pulse with wr_ack if the coordinates were out of range.
- clr_req  in  1  one-cycle pulse: fill the entire map.
- clr_idx  in  4  fill index, sampled with clr_req.
- busy  out  1  high while a write is pending or a clear is in progress.

Behaviour:
- Reset values: sprite_addr=0, wr_ack=0, wr_err=0, busy=0, FSM=IDLE. Map storage is not reset; after reset the system issues clr_req before enabling display.
- Read path:
  - sprite_addr <= map[current_tile] every cycle, regardless of vde. Latency is 1 cycle.
  - current_tile >= N_WORDS (255) yields sprite_addr <= 0.
  - A read and a write to the same word in the same cycle return the old data.
- Address arithmetic:
  - tile = wr_row*60 + wr_col, 11-bit unsigned.
  - word = tile>>3; nibble = tile[2:0].
  - A write updates only bits [4*nibble +: 4]; no read-modify-write of the other nibbles.
- FSM states: IDLE, WPEND, CLEAR.
- IDLE:
  - clr_req=1 → latch clr_idx, clear pointer=0 → CLEAR. clr_req wins over a simultaneous wr_req; that wr_req stays pending.
  - Else wr_req=1 → register word, nibble and wr_idx, plus range flag (wr_col>=60 or wr_row>=34) → WPEND.
- WPEND:
  - Out-of-range: wr_ack=1, wr_err=1 in the first WPEND cycle, no map change → IDLE.
  - Otherwise wait for a cycle with vde=0, commit the write that cycle, pulse wr_ack → IDLE.
  - Earliest ack is 1 cycle after wr_req is sampled.
  - The requester holds wr_req and the data stable until ack and drops wr_req the cycle after ack. A wr_req still high in IDLE after ack is a new request.
  - clr_req in WPEND is ignored.
- CLEAR:
  - In each cycle with vde=0, write {8{clr_idx}} to map[ptr] and ptr++; with vde=1, pause and hold ptr.
  - After writing ptr=254 → IDLE.
  - clr_req during CLEAR is ignored. wr_req during CLEAR is not acked; it is served from IDLE afterwards.
- busy = (state != IDLE). It rises the cycle after clr_req or wr_req is sampled and falls the cycle after the final commit or ack.
- Reset mid-operation: outputs return to reset values immediately. A partial clear leaves the map partially filled. No ack is issued for an aborted request.
- Widths: ptr is 8 bits and never reaches 255. All arithmetic is unsigned.

Test Plan:
- Reset, clr_req with clr_idx=3, vde=0 held → busy high for exactly 255 cycles; then current_tile=0..254 all give sprite_addr=0x33333333; current_tile=255 gives 0.
- After clear with 0, vde=0, write row=1 col=5 idx=0xA → ack at cycle 1; tile 65 → word 8, nibble 1; current_tile=8 gives 0x000000A0.
- wr_req while vde=1 for 100 cycles, then vde=0 → no ack during active video; ack and commit in the first vde=0 cycle; sprite_addr unchanged until then.
- Write col=60 row=0 → wr_ack and wr_err pulse together after 1 cycle; full map readback unchanged.
- clr_req and wr_req asserted in the same cycle, with vde toggling 50/50 → clear completes first (ptr pauses during vde=1), then the write is acked; final map is fill value plus the single written nibble.
- Assert rst_n=0 mid-clear at ptr=100 → busy and sprite_addr go to 0 asynchronously; after release, a new clr_req completes normally in 255 blanking cycles.
